// File: rtl/serial_mem_cmd_ctrl_if.sv
// Memory-side request/response bus of serial_mem_cmd_ctrl.
// master: the command controller (issues requests); slave: the memory controller.
interface serial_mem_cmd_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/serial_mem_cmd_ctrl.sv
// Serial command sequencer for HyperRAM accesses.
// Assembles 5-byte frames (cmd + 32-bit payload, MSB first) from the byte
// receiver, issues single-word read/write requests on the memory bus and
// streams the response bytes to the byte transmitter.
// Optional build macro: SERIAL_MEM_AUTO_INC_EN -- address register advances
// by 4 after every completed (non timed-out) memory access.
module serial_mem_cmd_ctrl #(
    parameter int FRAME_GAP   = 1000,  // 1..65535
    parameter int MEM_TIMEOUT = 256    // 1..65535
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_strb,
    input  logic [7:0]                    rx_data,
    output logic                          tx_strb,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    serial_mem_cmd_ctrl_if.master         mem,
    output logic                          busy,
    output logic [7:0]                    err_cnt
);

`ifdef SERIAL_MEM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP - 1);
    localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);

    localparam logic [7:0] CMD_SET_ADDR  = 8'h01;
    localparam logic [7:0] CMD_SET_WDATA = 8'h02;
    localparam logic [7:0] CMD_WRITE     = 8'h03;
    localparam logic [7:0] CMD_READ      = 8'h04;
    localparam logic [7:0] CMD_GET_ADDR  = 8'h05;
    localparam logic [7:0] RSP_OK        = 8'h00;
    localparam logic [7:0] RSP_ERR       = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RD,
        ST_TX_BYTE,
        ST_TX_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic        frame_rdy_q, frame_rdy_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        tx_strb_q, tx_strb_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] tx_shift_q, tx_shift_d;
    logic [2:0]  tx_left_q, tx_left_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Per-cycle scratch values used only inside the combinational block.
    logic [1:0]  err_inc;
    logic        tx_load;
    logic [31:0] tx_word;
    logic [2:0]  tx_cnt;
    logic        acc_done;
    logic [8:0]  err_sum;

    // Frame intake, command decode, memory handshake and transmit sequencing.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        frame_d     = frame_q;
        byte_cnt_d  = byte_cnt_q;
        frame_rdy_d = 1'b0;
        gap_cnt_d   = gap_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        to_cnt_d    = to_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_strb_d   = 1'b0;
        tx_data_d   = tx_data_q;
        tx_shift_d  = tx_shift_q;
        tx_left_d   = tx_left_q;
        err_inc     = 2'd0;
        tx_load     = 1'b0;
        tx_word     = 32'h0;
        tx_cnt      = 3'd0;
        acc_done    = 1'b0;

        // Byte intake only while idle; a stalled partial frame is discarded.
        if (rx_strb) begin
            if (state_q == ST_IDLE) begin
                frame_d   = {frame_q[31:0], rx_data};
                gap_cnt_d = 16'h0;
                if (byte_cnt_q == 3'd4) begin
                    byte_cnt_d  = 3'd0;
                    frame_rdy_d = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                end
            end else begin
                err_inc = err_inc + 2'd1;
            end
        end else if (state_q == ST_IDLE && byte_cnt_q != 3'd0) begin
            if (gap_cnt_q == GAP_LAST) begin
                gap_cnt_d  = 16'h0;
                byte_cnt_d = 3'd0;
                err_inc    = err_inc + 2'd1;
            end else begin
                gap_cnt_d = gap_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // The frame register still holds the completed frame here even
                // if a new first byte is being shifted in on this same edge.
                if (frame_rdy_q) begin
                    case (frame_q[39:32])
                        CMD_SET_ADDR:  addr_d  = frame_q[31:0];
                        CMD_SET_WDATA: wdata_d = frame_q[31:0];
                        CMD_WRITE, CMD_READ: begin
                            state_d     = ST_REQ;
                            mem_we_d    = (frame_q[39:32] == CMD_WRITE);
                            mem_addr_d  = addr_q;
                            mem_wdata_d = wdata_q;
                            to_cnt_d    = 16'h0;
                        end
                        CMD_GET_ADDR: begin
                            tx_load = 1'b1;
                            tx_word = addr_q;
                            tx_cnt  = 3'd4;
                        end
                        default: begin
                            tx_load = 1'b1;
                            tx_word = {RSP_ERR, 24'h0};
                            tx_cnt  = 3'd1;
                            err_inc = err_inc + 2'd1;
                        end
                    endcase
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    if (mem_we_q) begin
                        tx_load  = 1'b1;
                        tx_word  = {RSP_OK, 24'h0};
                        tx_cnt   = 3'd1;
                        acc_done = 1'b1;
                    end else if (mem.mem_rvalid) begin
                        tx_load  = 1'b1;
                        tx_word  = mem.mem_rdata;
                        tx_cnt   = 3'd4;
                        acc_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    tx_load = 1'b1;
                    tx_word = {RSP_ERR, 24'h0};
                    tx_cnt  = 3'd1;
                    err_inc = err_inc + 2'd1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_WAIT_RD: begin
                // The timeout keeps counting from the value reached in ST_REQ.
                if (mem.mem_rvalid) begin
                    tx_load  = 1'b1;
                    tx_word  = mem.mem_rdata;
                    tx_cnt   = 3'd4;
                    acc_done = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    tx_load = 1'b1;
                    tx_word = {RSP_ERR, 24'h0};
                    tx_cnt  = 3'd1;
                    err_inc = err_inc + 2'd1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            ST_TX_BYTE: begin
                if (!tx_busy) begin
                    tx_strb_d  = 1'b1;
                    tx_data_d  = tx_shift_q[31:24];
                    tx_shift_d = {tx_shift_q[23:0], 8'h00};
                    tx_left_d  = tx_left_q - 3'd1;
                    state_d    = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: begin
                // Gives the transmitter one cycle to raise tx_busy.
                state_d = (tx_left_q != 3'd0) ? ST_TX_BYTE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            tx_shift_d = tx_word;
            tx_left_d  = tx_cnt;
            state_d    = ST_TX_BYTE;
        end

        if (AUTO_INC && acc_done) begin
            addr_d = addr_q + 32'd4;
        end

        err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State and datapath registers; reset clears everything so every output reads 0 at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= 40'h0;
            byte_cnt_q  <= 3'd0;
            frame_rdy_q <= 1'b0;
            gap_cnt_q   <= 16'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            to_cnt_q    <= 16'h0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            tx_strb_q   <= 1'b0;
            tx_data_q   <= 8'h0;
            tx_shift_q  <= 32'h0;
            tx_left_q   <= 3'd0;
            err_cnt_q   <= 8'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q     <= state_d;
            frame_q     <= frame_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_rdy_q <= frame_rdy_d;
            gap_cnt_q   <= gap_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            to_cnt_q    <= to_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_strb_q   <= tx_strb_d;
            tx_data_q   <= tx_data_d;
            tx_shift_q  <= tx_shift_d;
            tx_left_q   <= tx_left_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign tx_strb       = tx_strb_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_cnt       = err_cnt_q;

endmodule
